input_ram_arbiter: RTL and testbench

Arbitrates the single-port input-matrix RAM between two requesters: the host loader (port H, fills and reads back the input matrix) and the accelerator controller (port A, fetches operands during LOAD). It sits between both requesters and the RAM macro and returns read data to whichever port issued the read. Arbitration is round-robin with a burst cap, so neither side starves. An accelerator lock keeps a compute burst uninterrupted.

---
 rtl/input_ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_input_ram_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_ram_arbiter.sv
// Round-robin arbiter sharing the single-port input-matrix RAM between the host loader (H)
// and the accelerator controller (A). The burst-cap starvation guard is enabled by ARB_STARVE_GUARD_EN.
module input_ram_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_lock,
  output logic              h_gnt,
  output logic              a_gnt,
  output logic              h_rvalid,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              arb_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_H = 2'd1,
    OWN_A = 2'd2
  } state_t;

  state_t            state;
  logic              last_owner;  // 1 = A owned the RAM most recently
  logic              force_h;
  logic              force_a;
  logic              leave_h;
  logic              leave_a;
  logic [RD_LAT-1:0] tag_vld_p;
  logic [RD_LAT-1:0] tag_port_p;  // 1 = read issued by A

  // Ownership decides the grant within the same cycle the request is seen
  assign h_gnt  = (state == OWN_H) && h_req;
  assign a_gnt  = (state == OWN_A) && a_req;
  assign ram_en = h_gnt | a_gnt;
  assign ram_we = (h_gnt & h_we) | (a_gnt & a_we);

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == OWN_H) begin
      ram_addr  = h_addr;
      ram_wdata = h_wdata;
    end else if (state == OWN_A) begin
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  logic [CNT_W-1:0] burst_cnt;
  logic             at_cap;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_W'(MAX_BURST)) ? v : v + CNT_W'(1);
  endfunction

  // The current accept is the MAX_BURST-th of this ownership, so hand over at this edge
  assign at_cap  = (burst_cnt >= CNT_W'(MAX_BURST - 1));
  assign force_h = h_gnt && at_cap && a_req;
  assign force_a = a_gnt && at_cap && h_req && !a_lock;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt <= '0;
    end else if (((state == OWN_H) && leave_h) || ((state == OWN_A) && leave_a)) begin
      burst_cnt <= '0;
    end else if (ram_en) begin
      burst_cnt <= sat_inc(burst_cnt);
    end
  end
`else
  logic unused_lock;

  assign unused_lock = a_lock;
  assign force_h     = 1'b0;
  assign force_a     = 1'b0;
`endif

  assign leave_h = !h_req || force_h;
  assign leave_a = !a_req || force_a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (h_req || a_req)
            state <= (h_req && (!a_req || last_owner)) ? OWN_H : OWN_A;
        end
        OWN_H: begin
          if (leave_h) begin
            state      <= a_req ? OWN_A : IDLE;
            last_owner <= 1'b0;
          end
        end
        OWN_A: begin
          if (leave_a) begin
            state      <= h_req ? OWN_H : IDLE;
            last_owner <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read tag pipeline: stage 0 captures accepted reads, stage RD_LAT-1 lines up with ram_rdata
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld_p  <= '0;
      tag_port_p <= '0;
    end else begin
      tag_vld_p[0]  <= ram_en & ~ram_we;
      tag_port_p[0] <= a_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_p[i]  <= tag_vld_p[i-1];
        tag_port_p[i] <= tag_port_p[i-1];
      end
    end
  end

  assign h_rvalid = tag_vld_p[RD_LAT-1] & ~tag_port_p[RD_LAT-1];
  assign a_rvalid = tag_vld_p[RD_LAT-1] &  tag_port_p[RD_LAT-1];
  assign h_rdata  = ram_rdata;
  assign a_rdata  = ram_rdata;
  assign arb_busy = (state != IDLE) || (|tag_vld_p);

endmodule

// File: tb/tb_input_ram_arbiter.sv
// Bench for input_ram_arbiter: directed scenarios plus randomized traffic against an ownership/memory reference model.
module tb_input_ram_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 16;
  localparam int MAXB = 16;
  localparam int LAT  = 3;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic h_req, h_we, a_req, a_we, a_lock;
  logic [AW-1:0] h_addr, a_addr;
  logic [DW-1:0] h_wdata, a_wdata;
  logic h_gnt, a_gnt, h_rvalid, a_rvalid, ram_en, ram_we, arb_busy;
  logic [DW-1:0] h_rdata, a_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  input_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_lock(a_lock),
    .h_gnt(h_gnt), .a_gnt(a_gnt), .h_rvalid(h_rvalid), .a_rvalid(a_rvalid),
    .h_rdata(h_rdata), .a_rdata(a_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .arb_busy(arb_busy)
  );

  // RAM macro with LAT-cycle read latency, zeroed on the first clock
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [0:LAT-1];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
      mem_ready <= 1'b1;
    end else if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    rpipe[0] <= mem[ram_addr];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[LAT-1];

  // Reference model: who owns the RAM, who owned it last, accepts in this ownership,
  // expected read returns and the memory contents seen through the arbiter
  typedef struct {int due; bit port; logic [DW-1:0] data;} rd_t;
  rd_t rq[$];
  logic [DW-1:0] mm [int];
  int owner, last_own, run, now;
  bit g_h, g_a;
  int n_vec, n_miss, n_hrv, n_arv;
  logic [DW-1:0] last_hrd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_h(input bit req, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    h_req = req; h_we = we; h_addr = ad; h_wdata = d;
  endtask

  task automatic set_a(input bit req, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_req = req; a_we = we; a_addr = ad; a_wdata = d;
  endtask

  // One clock: compare DUT against the model at the falling edge, advance the model, return 1 after the rising edge
  task automatic tick();
    bit eh, ea, erh, era, yr, xr, we;
    logic [DW-1:0] ed, wd;
    logic [AW-1:0] ad;
    int nxt;
    @(negedge clk);
    eh = (owner == 1) && h_req;
    ea = (owner == 2) && a_req;
    erh = 1'b0; era = 1'b0; ed = '0;
    if (rq.size() > 0 && rq[0].due == now) begin
      erh = !rq[0].port; era = rq[0].port; ed = rq[0].data;
    end
    check("h_gnt", 32'(h_gnt), 32'(eh));
    check("a_gnt", 32'(a_gnt), 32'(ea));
    check("ram_en", 32'(ram_en), 32'(eh | ea));
    check("h_rvalid", 32'(h_rvalid), 32'(erh));
    check("a_rvalid", 32'(a_rvalid), 32'(era));
    check("arb_busy", 32'(arb_busy), 32'((owner != 0) || (rq.size() > 0)));
    if (h_rvalid) begin n_hrv++; last_hrd = h_rdata; end
    if (a_rvalid) n_arv++;
    if (eh | ea) begin
      we = eh ? h_we : a_we;
      ad = eh ? h_addr : a_addr;
      wd = eh ? h_wdata : a_wdata;
      check("ram_we", 32'(ram_we), 32'(we));
      check("ram_addr", 32'(ram_addr), 32'(ad));
      if (we) check("ram_wdata", 32'(ram_wdata), 32'(wd));
      if (we) mm[int'(ad)] = wd;
      else rq.push_back('{now + LAT, ea, mm.exists(int'(ad)) ? mm[int'(ad)] : '0});
    end
    if (erh) check("h_rdata", 32'(h_rdata), 32'(ed));
    if (era) check("a_rdata", 32'(a_rdata), 32'(ed));
    if (erh | era) void'(rq.pop_front());
    if (owner == 0) begin
      if (h_req && a_req) owner = (last_own == 2) ? 1 : 2;
      else if (h_req) owner = 1;
      else if (a_req) owner = 2;
    end else begin
      xr = (owner == 1) ? h_req : a_req;
      yr = (owner == 1) ? a_req : h_req;
      nxt = owner;
      if (!xr) nxt = yr ? 3 - owner : 0;
      else begin
        run++;
        if (GUARD && run >= MAXB && yr && !(owner == 2 && a_lock)) nxt = 3 - owner;
      end
      if (nxt != owner) begin last_own = owner; run = 0; owner = nxt; end
    end
    g_h = eh; g_a = ea;
    now++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_h(0, 0, '0, '0); set_a(0, 0, '0, '0); a_lock = 1'b0;
    #1;
    check("rst_h_gnt", 32'(h_gnt), 0);
    check("rst_a_gnt", 32'(a_gnt), 0);
    check("rst_h_rvalid", 32'(h_rvalid), 0);
    check("rst_a_rvalid", 32'(a_rvalid), 0);
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_wdata", 32'(ram_wdata), 0);
    check("rst_arb_busy", 32'(arb_busy), 0);
    owner = 0; last_own = 2; run = 0; rq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs until both pending requests are served, dropping each request after its grant
  task automatic serve(input int max_cycles, output int first_port);
    int c;
    first_port = 0; c = 0;
    while ((h_req || a_req) && c < max_cycles) begin
      tick(); c++;
      if (g_h) begin if (first_port == 0) first_port = 1; h_req = 1'b0; end
      if (g_a) begin if (first_port == 0) first_port = 2; a_req = 1'b0; end
    end
    n_vec++;
    assert (!(h_req || a_req)) else begin
      n_miss++;
      $error("FAIL serve_timeout: requests still pending h=%0d a=%0d, expected none", h_req, a_req);
      h_req = 1'b0; a_req = 1'b0;
    end
  endtask

  initial begin
    int first, i, c, t0, tfirst, tlast, a_acc, hc, lastac;
    n_vec = 0; n_miss = 0; now = 0;
    reset = 1'b1;
    set_h(0, 0, '0, '0); set_a(0, 0, '0, '0); a_lock = 1'b0;
    #2;
    do_reset();

    // H write burst: addr 0..3, data 0x0011..0x0014
    t0 = now; tfirst = -1; tlast = -1; i = 0; c = 0;
    set_h(1, 1, 10'd0, 16'h0011);
    while (i < 4 && c < 20) begin
      tick(); c++;
      if (g_h) begin
        if (tfirst < 0) tfirst = now - t0;
        tlast = now - t0;
        i++;
        if (i < 4) set_h(1, 1, 10'(i), 16'h0011 + 16'(i));
        else h_req = 1'b0;
      end
    end
    check("wr_first_gnt_cycle", 32'(tfirst), 2);
    check("wr_gnt_span", 32'(tlast - tfirst), 3);
    tick();
    check("wr_back_to_idle", 32'(arb_busy), 0);
    tick();

    // H read-back of addr 2
    n_hrv = 0; n_arv = 0; last_hrd = '0;
    set_h(1, 0, 10'd2, '0);
    serve(10, first);
    repeat (LAT + 2) tick();
    check("rd_h_rvalid_count", 32'(n_hrv), 1);
    check("rd_h_rdata", 32'(last_hrd), 32'h0013);
    check("rd_a_rvalid_count", 32'(n_arv), 0);

    // Tie after reset goes to H; after an H-only ownership the next tie goes to A
    do_reset();
    set_h(1, 1, 10'd10, 16'h0AAA); set_a(1, 1, 10'd20, 16'h0BBB);
    serve(20, first);
    check("tie1_winner", 32'(first), 1);
    tick();
    set_h(1, 1, 10'd11, 16'h0AAB);
    serve(20, first);
    tick();
    set_h(1, 1, 10'd12, 16'h0AAC); set_a(1, 1, 10'd21, 16'h0BBC);
    serve(20, first);
    check("tie2_winner", 32'(first), 2);
    tick();

    // A streaming while H waits, first unlocked then locked
    for (int lk = 0; lk < 2; lk++) begin
      do_reset();
      a_lock = 1'(lk);
      set_a(1, 1, 10'd100, 16'h1000);
      tick();
      set_h(1, 1, 10'd200, 16'h0CCC);
      a_acc = 0; hc = -1; lastac = -1; c = 0;
      while (hc < 0 && c < 80) begin
        tick(); c++;
        if (g_a) begin
          a_acc++; lastac = now;
          if (a_acc == 40) a_req = 1'b0;
          else set_a(1, 1, 10'd100 + 10'(a_acc % 16), 16'h1000 + 16'(a_acc));
        end
        if (g_h) begin hc = now; h_req = 1'b0; end
      end
      check(lk ? "lock_a_accepts" : "starve_a_accepts", 32'(a_acc), (GUARD && lk == 0) ? 16 : 40);
      check(lk ? "lock_h_gap" : "starve_h_gap", 32'(hc - lastac), (GUARD && lk == 0) ? 1 : 2);
      a_lock = 1'b0;
      serve(60, first);
      repeat (2) tick();
    end

    // Reset one cycle after an accepted A read: the tag must never emerge
    do_reset();
    set_a(1, 0, 10'd2, '0);
    c = 0;
    while (c < 5) begin tick(); c++; if (g_a) c = 99; end
    a_req = 1'b0;
    do_reset();
    n_arv = 0;
    repeat (LAT + 3) tick();
    check("midrst_no_a_rvalid", 32'(n_arv), 0);

    // Randomized traffic on both ports with a wandering lock
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (!h_req || g_h) begin
        if ($urandom_range(0, 3) != 0)
          set_h(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 16'($urandom));
        else h_req = 1'b0;
      end
      if (!a_req || g_a) begin
        if ($urandom_range(0, 3) != 0)
          set_a(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 16'($urandom));
        else a_req = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) a_lock = ~a_lock;
      tick();
    end
    a_lock = 1'b0;
    serve(200, first);
    repeat (LAT + 3) tick();
    check("final_idle", 32'(arb_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
